// File: rtl/alarm_clock_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_controller
// Purpose  : Moore FSM sequencing the alarm clock display/load datapath.
//            Decodes keypad and buttons into display-select and load strobes
//            and abandons an idle key entry after TIMEOUT_SEC seconds.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_clock_controller #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_new_time,
  output logic       show_a,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count
);

  localparam int             CNT_W    = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             key_valid, timeout, waiting;
  logic             show_new_time_q, show_a_q, shift_q, load_new_a_q, load_new_c_q, reset_count_q;
  logic             show_new_time_d, show_a_d, shift_d, load_new_a_d, load_new_c_d, reset_count_d;

  // Next state, timeout counter and output decode of the upcoming state
  always_comb begin
    key_valid = (key != NOKEY) && (key < 4'd10);
    waiting   = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    timeout   = one_second && (count_q == CNT_LAST);

    // Counter runs only while waiting for keys; saturates at the last value
    count_d = '0;
    if (waiting) begin
      count_d = count_q;
      if (one_second && (count_q != CNT_LAST)) count_d = count_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)   state_d = SHOW_ALARM;
        else if (key_valid) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        // Release beats timeout so a late release still lands in entry
        if (!key_valid)   state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_d = SET_ALARM_TIME;
        else if (time_button) state_d = SET_CURRENT_TIME;
        else if (key_valid)   state_d = KEY_STORED;
        else if (timeout)     state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase

    // Outputs are registered from the next state so they equal a decode of state_q
    show_new_time_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY) ||
                      (state_d == SET_ALARM_TIME) || (state_d == SET_CURRENT_TIME);
    show_a_d        = (state_d == SHOW_ALARM);
    shift_d         = (state_d == KEY_STORED);
    load_new_a_d    = (state_d == SET_ALARM_TIME);
    load_new_c_d    = (state_d == SET_CURRENT_TIME);
    reset_count_d   = (state_d == SET_CURRENT_TIME);
  end

  // State, counter and registered Moore outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= SHOW_TIME;
      count_q         <= '0;
      show_new_time_q <= 1'b0;
      show_a_q        <= 1'b0;
      shift_q         <= 1'b0;
      load_new_a_q    <= 1'b0;
      load_new_c_q    <= 1'b0;
      reset_count_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      show_new_time_q <= show_new_time_d;
      show_a_q        <= show_a_d;
      shift_q         <= shift_d;
      load_new_a_q    <= load_new_a_d;
      load_new_c_q    <= load_new_c_d;
      reset_count_q   <= reset_count_d;
    end
  end

  assign show_new_time = show_new_time_q;
  assign show_a        = show_a_q;
  assign shift         = shift_q;
  assign load_new_a    = load_new_a_q;
  assign load_new_c    = load_new_c_q;
  assign reset_count   = reset_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_clock_controller
// Purpose  : Directed self-checking bench for alarm_clock_controller with a
//            behavioural model of the clock's operating modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_controller;

  localparam int TMO = 10;
  localparam logic [3:0] NK = 4'd10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NK;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       show_new_time, show_a, shift, load_new_a, load_new_c, reset_count;

  int tests = 0;
  int fails = 0;
  int n_shift = 0, n_loadc = 0, n_loada = 0;

  // Model modes: what the user is doing with the clock
  localparam int M_IDLE = 0, M_PRESS = 1, M_HELD = 2, M_ENTRY = 3,
                 M_ALARM = 4, M_SETA = 5, M_SETC = 6;
  int mode = M_IDLE;
  int secs = 0;   // seconds of inactivity seen since the last key was taken

  alarm_clock_controller #(.TIMEOUT_SEC(TMO), .NOKEY(NK)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key(key),
    .alarm_button(alarm_button), .time_button(time_button),
    .show_new_time(show_new_time), .show_a(show_a), .shift(shift),
    .load_new_a(load_new_a), .load_new_c(load_new_c), .reset_count(reset_count)
  );

  always #5 clock = ~clock;

  // {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count}
  function automatic logic [5:0] expect_out(input int m);
    case (m)
      M_PRESS: return 6'b001000;
      M_HELD:  return 6'b100000;
      M_ENTRY: return 6'b100000;
      M_ALARM: return 6'b010000;
      M_SETA:  return 6'b100100;
      M_SETC:  return 6'b100011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model from the inputs seen at this edge
  task automatic model_edge();
    bit digit, expired;
    int nxt;
    digit   = (key <= 4'd9);
    expired = one_second && (secs + 1 >= TMO);
    nxt = mode;
    if (reset) begin
      mode = M_IDLE; secs = 0;
      return;
    end
    if (mode == M_IDLE)       nxt = alarm_button ? M_ALARM : (digit ? M_PRESS : M_IDLE);
    else if (mode == M_PRESS) nxt = M_HELD;
    else if (mode == M_HELD)  nxt = !digit ? M_ENTRY : (expired ? M_IDLE : M_HELD);
    else if (mode == M_ENTRY) nxt = alarm_button ? M_SETA : time_button ? M_SETC :
                                    digit ? M_PRESS : expired ? M_IDLE : M_ENTRY;
    else if (mode == M_ALARM) nxt = alarm_button ? M_ALARM : M_IDLE;
    else                      nxt = M_IDLE;
    if (mode == M_HELD || mode == M_ENTRY) begin
      if (one_second && secs < TMO - 1) secs++;
    end else begin
      secs = 0;
    end
    mode = nxt;
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("outputs", {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count},
          expect_out(mode));
    n_shift += int'(shift);
    n_loadc += int'(load_new_c);
    n_loada += int'(load_new_a);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] k);
    key = k; ticks(3);
    key = NK; ticks(2);
  endtask

  task automatic second();
    one_second = 1'b1; tick();
    one_second = 1'b0;
  endtask

  task automatic seconds_idle(input int n);
    for (int i = 0; i < n; i++) begin
      second(); ticks(7);
    end
  endtask

  initial begin
    // Reset held with a key and the alarm button active
    @(negedge clock);
    reset = 1'b1; key = 4'd5; alarm_button = 1'b1;
    tick();
    check("reset_c1", {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count}, 6'b0);
    tick();
    check("reset_c2", {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count}, 6'b0);
    reset = 1'b0; key = NK; alarm_button = 1'b0;
    ticks(2);

    // time_button and out-of-range codes ignored at idle
    time_button = 1'b1; tick(); time_button = 1'b0;
    key = 4'd12; ticks(2); key = NK; tick();
    check("idle_ignore", {5'b0, show_new_time}, 6'b0);

    // Four digits then load current time
    n_shift = 0; n_loadc = 0;
    press(4'd1);
    check("snt_after_shift", {5'b0, show_new_time}, 6'b1);
    press(4'd2); press(4'd3); press(4'd4);
    check("shift_count", 6'(n_shift), 6'd4);
    time_button = 1'b1; tick(); time_button = 1'b0;
    check("load_c_pulse", {4'b0, load_new_c, reset_count}, 6'b11);
    ticks(3);
    check("load_c_count", 6'(n_loadc), 6'd1);

    // Set alarm with the button held, then show alarm until release
    n_loada = 0;
    press(4'd7);
    alarm_button = 1'b1; ticks(4);
    check("show_a_held", {5'b0, show_a}, 6'b1);
    alarm_button = 1'b0; tick();
    check("show_a_drop", {5'b0, show_a}, 6'b0);
    check("load_a_count", 6'(n_loada), 6'd1);
    ticks(2);

    // Timeout after ten idle seconds
    press(4'd8);
    seconds_idle(9);
    check("tmo_9", {5'b0, show_new_time}, 6'b1);
    second();
    check("tmo_10", {5'b0, show_new_time}, 6'b0);
    ticks(3);

    // A new key restarts the timeout
    press(4'd3);
    seconds_idle(9);
    press(4'd4);
    seconds_idle(9);
    check("restart_9", {5'b0, show_new_time}, 6'b1);
    second();
    check("restart_10", {5'b0, show_new_time}, 6'b0);
    ticks(3);

    // Both buttons with the tenth second: alarm wins
    press(4'd5);
    seconds_idle(9);
    alarm_button = 1'b1; time_button = 1'b1; one_second = 1'b1;
    tick();
    alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    check("prio_alarm", {3'b0, load_new_a, load_new_c, show_new_time}, 6'b000101);
    ticks(3);
    check("prio_end", {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count}, 6'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
- Moore FSM that sequences the alarm clock's display/load datapath.
- Decodes keypad and button activity into the mode controls for the display multiplexer (show_new_time, show_a), the key entry shift register (shift), the alarm register (load_new_a) and the time counter (load_new_c, reset_count).
- Contains a per-second timeout counter that abandons an idle key entry and returns to normal time display.

Parameters:
- TIMEOUT_SEC, 10, number of one_second pulses of inactivity in KEY_WAITED/KEY_ENTRY before returning to SHOW_TIME.
- NOKEY, 4'd10, keypad code meaning "no key pressed"; codes 0-9 are digits; 11-15 are treated as NOKEY.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; forces the reset state on the next rising edge.
- one_second  input  1  single-cycle pulse once per second from the timegen block.
- key  input  4  current keypad code, held while a key is pressed.
- alarm_button  input  1  level, high while the alarm button is pressed.
- time_button  input  1  level, high while the time-set button is pressed.
- show_new_time  output  1  display selects key entry digits.
- show_a  output  1  display selects alarm time.
- shift  output  1  one-cycle strobe: shift key into the key entry register.
- load_new_a  output  1  one-cycle strobe: load key entry into alarm register.
- load_new_c  output  1  one-cycle strobe: load key entry into current time counter.
- reset_count  output  1  one-cycle strobe: clear the seconds prescaler (asserted together with load_new_c).

Behaviour:
- States (3-bit encoding): SHOW_TIME=0, KEY_STORED=1, KEY_WAITED=2, KEY_ENTRY=3, SHOW_ALARM=4, SET_ALARM_TIME=5, SET_CURRENT_TIME=6. Code 7 is illegal and goes to SHOW_TIME on the next edge.
- Outputs are decoded from the state register only (pure Moore), so there is no input-to-output combinational path.
  - SHOW_TIME: all outputs 0.
  - KEY_STORED: shift=1.
  - KEY_WAITED: show_new_time=1.
  - KEY_ENTRY: show_new_time=1.
  - SHOW_ALARM: show_a=1.
  - SET_ALARM_TIME: load_new_a=1, show_new_time=1.
  - SET_CURRENT_TIME: load_new_c=1, reset_count=1, show_new_time=1.
- Reset: state=SHOW_TIME and count=0, so all outputs are 0 in the cycle after the reset edge. Reset overrides all inputs and aborts any entry in progress. The key entry register is not cleared by this block.
- Key validity: a key is valid when key is 0-9.
- Transitions, evaluated each rising edge. Listed priority order is top-down within a state.
  - SHOW_TIME:
    - alarm_button -> SHOW_ALARM.
    - valid key -> KEY_STORED.
    - else stay.
  - KEY_STORED: unconditional -> KEY_WAITED. shift is therefore exactly one cycle per key press.
  - KEY_WAITED:
    - key not valid (released) -> KEY_ENTRY.
    - timeout -> SHOW_TIME.
    - else stay. A held key never re-shifts.
  - KEY_ENTRY:
    - alarm_button -> SET_ALARM_TIME.
    - time_button -> SET_CURRENT_TIME.
    - valid key -> KEY_STORED.
    - timeout -> SHOW_TIME.
    - else stay.
  - SHOW_ALARM:
    - alarm_button low -> SHOW_TIME.
    - else stay. Keys and time_button are ignored.
  - SET_ALARM_TIME: unconditional -> SHOW_TIME.
  - SET_CURRENT_TIME: unconditional -> SHOW_TIME.
- Timeout counter:
  - Width is ceil(log2(TIMEOUT_SEC)), 4 bits at the default.
  - Cleared in every state other than KEY_WAITED/KEY_ENTRY. It is therefore cleared in KEY_STORED, and each new key restarts the timeout.
  - In KEY_WAITED/KEY_ENTRY it increments on each one_second pulse.
  - timeout = one_second && (count == TIMEOUT_SEC-1), so exit happens on the TIMEOUT_SEC-th pulse after entry.
  - The counter saturates and never wraps while in those states.
- Simultaneous events:
  - alarm_button and time_button both high in KEY_ENTRY -> SET_ALARM_TIME.
  - Button and timeout on the same edge -> the button wins.
  - Valid key and timeout in KEY_ENTRY -> KEY_STORED.
  - Key release and timeout in KEY_WAITED -> KEY_ENTRY.
- time_button in SHOW_TIME is ignored; there is no load without prior key entry.

Test Plan:
- Reset: assert reset for 2 cycles with key=5 and alarm_button=1 -> state SHOW_TIME, all six outputs 0 after the reset edge; no transition while reset is high.
- Digit entry:
  - Key sequence 1,2,3,4, each held 3 cycles with NOKEY gaps of 2 cycles -> exactly 4 single-cycle shift pulses.
  - show_new_time=1 from the cycle after the first shift through the end of entry.
- Set time: after entering 4 digits, pulse time_button for 1 cycle -> load_new_c=1 and reset_count=1 for exactly one cycle, then SHOW_TIME with all outputs 0.
- Set alarm and show alarm:
  - After entry, alarm_button high -> load_new_a pulses once, then SHOW_TIME.
  - alarm_button still held -> SHOW_ALARM with show_a=1; show_a drops the cycle after alarm_button falls.
- Timeout:
  - Enter one digit, then idle with one_second every 8 cycles -> return to SHOW_TIME on the 10th pulse; show_new_time is 0 the next cycle.
  - Repeat with a new key after the 9th pulse -> counter restarts, requiring 10 further pulses.
- Priority: in KEY_ENTRY, raise alarm_button and time_button together with one_second on pulse 10 -> SET_ALARM_TIME (load_new_a=1, load_new_c=0).
